// File: rtl/instr_fetch.sv
// Instruction fetch: one req/ack read per PC value, held for decode behind a valid/ready handshake.
// Drops fetches made stale by a jump (flush) and raises a sticky error on reads that never ack.
//
// state | meaning
// IDLE  | no read outstanding; latch pc_addr and start a read unless the PC is loading a jump
// REQ   | read outstanding for the current PC
// HOLD  | instruction held for decode, waiting for instr_ready
// DRAIN | read outstanding but already stale; wait for the ack and throw the data away
module instr_fetch #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 15,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] pc_addr,
    input  logic                 flush,
    output logic                 pc_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_req,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_req_q, mem_req_d;
    logic [WORD_SIZE-1:0]   instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;

    // Saturating so a stuck count can never wrap back below the limit.
    assign cnt_inc = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_req_d     = mem_req_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        cnt_d         = cnt_q;
        pc_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    mem_addr_d = pc_addr;
                    mem_req_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!flush) begin
                        instr_d       = mem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        fetch_err_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        fetch_err_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // A jump wins over acceptance: the held word belongs to the old path.
                if (flush) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end else if (instr_ready) begin
                    pc_en         = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_req     = mem_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, a transaction-level reference checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_instr_fetch;

    localparam int WS = 32;
    localparam int AS = 15;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AS-1:0] pc_addr;
    logic          flush;
    logic          pc_en;
    logic [AS-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [WS-1:0] mem_rdata;
    logic [WS-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .flush       (flush),
        .pc_en       (pc_en),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents.
    function automatic logic [WS-1:0] mem_word(input logic [AS-1:0] a);
        return {2'b01, a, a};
    endfunction

    // Memory responder: acks after `lat` wait cycles of an open request.
    int            lat     = 0;
    bit            ack_en  = 1'b1;
    bit            ovr_en  = 1'b0;
    logic [WS-1:0] ovr_data = '0;
    int            rcnt    = 0;

    task automatic respond();
        if (mem_req) begin
            mem_ack   = ack_en && (rcnt == lat);
            mem_rdata = mem_ack ? (ovr_en ? ovr_data : mem_word(mem_addr)) : '0;
            rcnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            rcnt      = 0;
        end
    endtask

    // Reference: one outstanding read at most, a held word, a stale marker and a wait count.
    bit            m_req, m_stale, m_have, m_err;
    logic [AS-1:0] m_addr;
    logic [WS-1:0] m_instr;
    int            m_wait;

    // Inputs as seen by the upcoming clock edge.
    bit            c_rst = 1'b1;
    bit            c_flush, c_ready, c_ack, c_pc_en;
    logic [WS-1:0] c_rdata;
    logic [AS-1:0] c_pc;

    task automatic model_step();
        if (c_rst) begin
            m_req = 0; m_stale = 0; m_have = 0; m_err = 0;
            m_addr = '0; m_instr = '0; m_wait = 0;
        end else if (m_have) begin
            if (c_flush || c_ready) m_have = 0;
        end else if (m_req) begin
            if (c_ack) begin
                m_req = 0;
                if (!m_stale && !c_flush) begin
                    m_have  = 1;
                    m_instr = c_rdata;
                end
                m_stale = 0;
            end else if (!m_stale && c_flush) begin
                m_stale = 1;
            end else begin
                m_wait++;
                if (m_wait >= TO) begin
                    m_err = 1; m_req = 0; m_stale = 0;
                end
            end
        end else if (!c_flush) begin
            m_req  = 1;
            m_addr = c_pc;
            m_wait = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        if (c_pc_en) pc_addr = pc_addr + 1'b1;
        respond();
    endtask

    bit       cmp_en = 1'b0;
    bit       log_en = 1'b0;
    bit       prev_req = 1'b0;
    int       ncyc = 0;
    int       q_addr[$];
    logic [WS-1:0] q_instr[$];
    int       q_pcen_cyc[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_req",     mem_req,     m_req);
            chk("mem_addr",    mem_addr,    m_addr);
            chk("instr_valid", instr_valid, m_have);
            chk("instr",       instr,       m_instr);
            chk("fetch_err",   fetch_err,   m_err);
            chk("pc_en",       pc_en,       m_have && instr_ready && !flush);
        end
        if (log_en) begin
            if (mem_req && !prev_req) q_addr.push_back(int'(mem_addr));
            if (pc_en) begin
                q_instr.push_back(instr);
                q_pcen_cyc.push_back(ncyc);
            end
        end
        prev_req = mem_req;
        ncyc++;
        c_rst   = rst;
        c_flush = flush;
        c_ready = instr_ready;
        c_ack   = mem_ack;
        c_rdata = mem_rdata;
        c_pc    = pc_addr;
        c_pc_en = pc_en;
    end

    bit seen_valid;
    int guard;

    initial begin
        rst = 1'b1; flush = 1'b0; instr_ready = 1'b1; pc_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 0);
        chk("rst_fetch_err", fetch_err, 1'b0);

        // Zero-latency memory, decode always ready.
        rst = 1'b0;
        log_en = 1'b1;
        repeat (9) tick();
        log_en = 1'b0;
        chk("seq_req_count", q_addr.size(), 3);
        chk("seq_pcen_count", q_pcen_cyc.size(), 3);
        if (q_addr.size() == 3 && q_pcen_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("seq_addr", q_addr[i], i);
                chk("seq_instr", q_instr[i], mem_word(AS'(i)));
            end
            chk("seq_pcen_gap01", q_pcen_cyc[1] - q_pcen_cyc[0], 3);
            chk("seq_pcen_gap12", q_pcen_cyc[2] - q_pcen_cyc[1], 3);
        end
        chk("seq_pc", pc_addr, 3);

        // Four cycles of ack latency.
        lat = 4;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lat_req_high", mem_req, 1'b1);
            chk("lat_addr_stable", mem_addr, 3);
            chk("lat_no_valid", instr_valid, 1'b0);
        end
        tick();
        chk("lat_valid", instr_valid, 1'b1);
        chk("lat_instr", instr, mem_word(AS'(3)));
        chk("lat_err", fetch_err, 1'b0);
        tick();

        // Decode stalls for five cycles.
        lat = 0;
        instr_ready = 1'b0;
        tick();
        tick();
        chk("stall_instr", instr, mem_word(AS'(4)));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr_hold", instr, mem_word(AS'(4)));
            chk("stall_pc_en", pc_en, 1'b0);
        end
        instr_ready = 1'b1;
        #1;
        chk("stall_release_pc_en", pc_en, 1'b1);
        tick();
        chk("stall_valid_drop", instr_valid, 1'b0);
        chk("stall_pc", pc_addr, 5);

        // Jump while a read is outstanding; its late data must be dropped.
        lat = 2; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        seen_valid = 1'b0;
        tick();
        chk("drain_req", mem_req, 1'b1);
        flush = 1'b1; pc_addr = AS'(16'h0040);
        tick();
        seen_valid |= instr_valid;
        flush = 1'b0;
        tick();
        seen_valid |= instr_valid;
        chk("drain_ack_seen", mem_ack, 1'b1);
        tick();
        seen_valid |= instr_valid;
        chk("drain_req_drop", mem_req, 1'b0);
        chk("drain_never_valid", seen_valid, 1'b0);
        ovr_en = 1'b0; lat = 0;
        tick();
        chk("jump_req", mem_req, 1'b1);
        chk("jump_addr", mem_addr, 16'h0040);
        tick();
        chk("jump_valid", instr_valid, 1'b1);
        chk("jump_instr", instr, mem_word(AS'(16'h0040)));

        // Flush and ready together in HOLD: flush wins.
        flush = 1'b1; instr_ready = 1'b1; pc_addr = AS'(16'h0100);
        #1;
        chk("flush_hold_pc_en", pc_en, 1'b0);
        tick();
        chk("flush_hold_valid", instr_valid, 1'b0);
        flush = 1'b0;
        ack_en = 1'b0;
        tick();
        chk("flush_next_addr", mem_addr, 16'h0100);
        chk("flush_next_req", mem_req, 1'b1);

        // Memory never acknowledges.
        repeat (TO - 1) tick();
        chk("to_still_req", mem_req, 1'b1);
        chk("to_no_err_yet", fetch_err, 1'b0);
        tick();
        chk("to_err", fetch_err, 1'b1);
        chk("to_req_drop", mem_req, 1'b0);
        guard = 0;
        while (!mem_req && guard < 5) begin
            tick();
            guard++;
        end
        chk("retry_req", mem_req, 1'b1);
        chk("retry_addr", mem_addr, 16'h0100);
        chk("retry_err_sticky", fetch_err, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_req", mem_req, 1'b0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_err", fetch_err, 1'b0);
        chk("mid_rst_valid", instr_valid, 1'b0);
        chk("mid_rst_instr", instr, 0);
        rst = 1'b0; ack_en = 1'b1;
        repeat (4) tick();
        chk("post_rst_err", fetch_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
